// File: rtl/ocr_pkg.sv
// Shared OCR constants and the loader state encoding.
package ocr_pkg;

    localparam int unsigned OCR_ADDR_W = 10;
    localparam int unsigned OCR_DATA_W = 32;
    localparam int unsigned OCR_DEPTH  = 1024;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE
    } loader_state_t;

endpackage

// File: rtl/ocr_stream_loader.sv
// Streams Avalon-ST beats into the OCR as single-cycle Avalon-MM writes.
// Optional running checksum of written words: define OCR_STREAM_LOADER_CHECKSUM_EN.
module ocr_stream_loader
    import ocr_pkg::*;
#(
    parameter int unsigned ADDR_W = OCR_ADDR_W,
    parameter int unsigned DATA_W = OCR_DATA_W,
    parameter int unsigned BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    input  logic [DATA_W-1:0] snk_data,
    input  logic [BE_W-1:0]   snk_byteen,
    input  logic              snk_valid,
    output logic              snk_ready,
    output logic [ADDR_W-1:0] ocr_address,
    output logic [BE_W-1:0]   ocr_byteenable,
    output logic              ocr_chipselect,
    output logic              ocr_write,
    output logic [DATA_W-1:0] ocr_writedata,
    output logic              ocr_clken,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W:0] MaxWords = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] OneWord  = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              aborted_q, aborted_d;
    logic              accept;
    logic [ADDR_W:0]   count_clamped;

    // Write stage: one registered beat, issued the cycle after it is accepted.
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [BE_W-1:0]   wr_be_q, wr_be_d;

    assign count_clamped = (word_count > MaxWords) ? MaxWords : word_count;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        aborted_d  = aborted_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_be_d    = wr_be_q;
        snk_ready  = 1'b0;
        accept     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    aborted_d = 1'b0;
                    if (word_count == '0) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = start_addr;
                        rem_d   = count_clamped;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                snk_ready = (rem_q != '0) && !abort;
                accept    = snk_valid && snk_ready;
                if (accept) begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = addr_q;
                    wr_data_d  = snk_data;
                    wr_be_d    = snk_byteen;
                    addr_d     = addr_q + 1'b1;
                    rem_d      = rem_q - OneWord;
                    if (rem_q == OneWord) begin
                        state_d = FLUSH;
                    end
                end
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = FLUSH;
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            aborted_q  <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_be_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            aborted_q  <= aborted_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_be_q    <= wr_be_d;
        end
    end

`ifdef OCR_STREAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;

    // Summed at accept so the total already includes a word in its write cycle.
    always_comb begin
        sum_d = sum_q;
        if (state_q == IDLE && start) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + snk_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign aborted        = done && aborted_q;
    assign ocr_write      = wr_valid_q;
    assign ocr_chipselect = wr_valid_q;
    assign ocr_address    = wr_addr_q;
    assign ocr_writedata  = wr_data_q;
    assign ocr_byteenable = wr_be_q;
    assign ocr_clken      = 1'b1;

endmodule

// File: tb/tb_ocr_stream_loader.sv
// Self-checking bench for ocr_stream_loader: directed table, corner sequences, random loads.
module tb_ocr_stream_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  start_addr;
    logic [10:0] word_count;
    logic        abort;
    logic        busy, done, aborted;
    logic [31:0] snk_data;
    logic [3:0]  snk_byteen;
    logic        snk_valid;
    logic        snk_ready;
    logic [9:0]  ocr_address;
    logic [3:0]  ocr_byteenable;
    logic        ocr_chipselect, ocr_write, ocr_clken;
    logic [31:0] ocr_writedata;
    logic [31:0] checksum;

    ocr_stream_loader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .start_addr     (start_addr),
        .word_count     (word_count),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .snk_data       (snk_data),
        .snk_byteen     (snk_byteen),
        .snk_valid      (snk_valid),
        .snk_ready      (snk_ready),
        .ocr_address    (ocr_address),
        .ocr_byteenable (ocr_byteenable),
        .ocr_chipselect (ocr_chipselect),
        .ocr_write      (ocr_write),
        .ocr_writedata  (ocr_writedata),
        .ocr_clken      (ocr_clken),
        .checksum       (checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Observed OCR writes and done pulses.
    int          mon_cyc[$];
    logic [9:0]  mon_addr[$];
    logic [31:0] mon_data[$];
    logic [3:0]  mon_be[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        done_ab = 1'b0;
    logic [31:0] done_sum = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        checks++;
        if (ocr_chipselect !== ocr_write || ocr_clken !== 1'b1) begin
            failures++;
            $display("FAIL cs_clken actual=%b%b%b required=cs==write,clken=1",
                     ocr_chipselect, ocr_write, ocr_clken);
        end
        if (ocr_write === 1'b1) begin
            mon_cyc.push_back(cyc);
            mon_addr.push_back(ocr_address);
            mon_data.push_back(ocr_writedata);
            mon_be.push_back(ocr_byteenable);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            done_ab  = aborted;
            done_sum = checksum;
        end
    end

    task automatic clear_monitor();
        mon_cyc.delete();
        mon_addr.delete();
        mon_data.delete();
        mon_be.delete();
        done_cnt = 0;
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 back in IDLE.
    task automatic run_load(input string nm, input int sa, input int wc, input int ab_after,
                            input int gap, input bit rnd, input int exp_n, input bit exp_ab);
        logic [31:0] beats[$];
        logic [3:0]  bes[$];
        int          acc_cyc[$];
        int          eff, acc, budget, start_cyc, n;
        bit          sent;
        logic [31:0] sum, exp_sum;
        eff = (wc > 1024) ? 1024 : wc;
        for (int i = 0; i < eff; i++) begin
            beats.push_back(rnd ? $urandom : 32'(i + 1) * 32'h11);
            bes.push_back(4'($urandom));
        end
        clear_monitor();
        start      = 1'b1;
        start_addr = 10'(sa);
        word_count = 11'(wc);
        start_cyc  = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        acc = 0;
        sent = 1'b0;
        budget = 0;
        if (wc != 0) begin
            while ((acc < exp_n || (ab_after >= 0 && ab_after < eff && !sent)) && budget < 5000) begin
                abort     = 1'b0;
                snk_valid = 1'b0;
                start     = 1'b0;
                if (ab_after >= 0 && ab_after < eff && acc == ab_after && !sent) begin
                    abort = 1'b1;
                    sent  = 1'b1;
                end else if (acc < exp_n) begin
                    case (gap)
                        0:       snk_valid = 1'b1;
                        1:       snk_valid = (budget % 2 == 0);
                        default: snk_valid = 1'($urandom_range(0, 1));
                    endcase
                    snk_data   = beats[acc];
                    snk_byteen = bes[acc];
                    if (rnd && $urandom_range(0, 7) == 0) begin
                        start      = 1'b1;
                        start_addr = 10'($urandom);
                        word_count = 11'd1;
                    end
                end
                @(negedge clk);
                if (snk_valid && snk_ready) begin
                    acc_cyc.push_back(cyc);
                    acc++;
                end
                @(posedge clk); #1;
                budget++;
            end
            check({nm, "_load_budget"}, budget < 5000, 1);
        end
        abort     = 1'b0;
        snk_valid = 1'b0;
        start     = 1'b0;
        if (!exp_ab && exp_n > 0) begin
            @(negedge clk);
            check({nm, "_ready_after_last"}, snk_ready, 0);
        end
        budget = 0;
        while (done_cnt == 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        repeat (2) @(posedge clk);
        #1;
        check({nm, "_done_count"}, done_cnt, 1);
        check({nm, "_aborted"}, done_ab, exp_ab);
        check({nm, "_nwrites"}, mon_addr.size(), exp_n);
        n = (mon_addr.size() < exp_n) ? mon_addr.size() : exp_n;
        sum = '0;
        for (int i = 0; i < n; i++) begin
            check({nm, "_addr"}, mon_addr[i], (sa + i) % 1024);
            check({nm, "_data"}, mon_data[i], beats[i]);
            check({nm, "_be"}, mon_be[i], bes[i]);
            check({nm, "_latency"}, mon_cyc[i], acc_cyc[i] + 1);
            sum = sum + beats[i];
        end
`ifdef OCR_STREAM_LOADER_CHECKSUM_EN
        exp_sum = sum;
`else
        exp_sum = '0;
`endif
        check({nm, "_checksum"}, done_sum, exp_sum);
        if (wc == 0) begin
            check({nm, "_done_cyc"}, done_cyc, start_cyc + 1);
        end else if (!exp_ab && exp_n > 0) begin
            check({nm, "_done_cyc"}, done_cyc, acc_cyc[exp_n-1] + 2);
        end
        check({nm, "_idle_busy"}, busy, 0);
    endtask

    typedef struct {
        int sa;
        int wc;
        int ab;
        int gap;
        int exp_n;
        bit exp_ab;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sa, wc, ab, en;
        bit eab;
        int acc, budget;

        vecs[0] = '{sa: 0,    wc: 4,    ab: -1, gap: 0, exp_n: 4,    exp_ab: 1'b0};
        vecs[1] = '{sa: 1022, wc: 4,    ab: -1, gap: 0, exp_n: 4,    exp_ab: 1'b0};
        vecs[2] = '{sa: 7,    wc: 0,    ab: -1, gap: 0, exp_n: 0,    exp_ab: 1'b0};
        vecs[3] = '{sa: 50,   wc: 6,    ab: -1, gap: 1, exp_n: 6,    exp_ab: 1'b0};
        vecs[4] = '{sa: 200,  wc: 10,   ab: 3,  gap: 0, exp_n: 3,    exp_ab: 1'b1};
        vecs[5] = '{sa: 1020, wc: 8,    ab: -1, gap: 2, exp_n: 8,    exp_ab: 1'b0};
        vecs[6] = '{sa: 5,    wc: 1100, ab: -1, gap: 0, exp_n: 1024, exp_ab: 1'b0};
        vecs[7] = '{sa: 300,  wc: 1,    ab: -1, gap: 0, exp_n: 1,    exp_ab: 1'b0};
        vecs[8] = '{sa: 400,  wc: 5,    ab: 0,  gap: 0, exp_n: 0,    exp_ab: 1'b1};

        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        word_count = '0;
        abort      = 1'b0;
        snk_data   = '0;
        snk_byteen = '0;
        snk_valid  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_ready", snk_ready, 0);
        check("rst_write", ocr_write, 0);
        check("rst_cs", ocr_chipselect, 0);
        check("rst_addr", ocr_address, 0);
        check("rst_be", ocr_byteenable, 0);
        check("rst_wdata", ocr_writedata, 0);
        check("rst_checksum", checksum, 0);
        check("rst_clken", ocr_clken, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // abort while idle has no effect
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_busy", busy, 0);
        check("idle_abort_done", done, 0);
        @(posedge clk); #1;

        for (int v = 0; v < 9; v++) begin
            run_load($sformatf("vec%0d", v), vecs[v].sa, vecs[v].wc, vecs[v].ab, vecs[v].gap,
                     1'b0, vecs[v].exp_n, vecs[v].exp_ab);
        end

        // Reset in the middle of a load after two accepted beats.
        clear_monitor();
        start      = 1'b1;
        start_addr = 10'd100;
        word_count = 11'd10;
        @(posedge clk); #1;
        start = 1'b0;
        acc = 0;
        budget = 0;
        while (acc < 2 && budget < 50) begin
            snk_valid  = 1'b1;
            snk_data   = 32'hA000_0000 + 32'(acc);
            snk_byteen = 4'hF;
            @(negedge clk);
            if (snk_ready) acc++;
            @(posedge clk); #1;
            budget++;
        end
        snk_valid = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_accepts", acc, 2);
        check("midrst_writes_le2", mon_addr.size() <= 2, 1);
        check("midrst_no_done", done_cnt, 0);
        check("midrst_busy", busy, 0);
        check("midrst_write", ocr_write, 0);
        run_load("after_rst", 100, 5, -1, 0, 1'b0, 5, 1'b0);

        for (int r = 0; r < 25; r++) begin
            sa = $urandom_range(0, 1023);
            wc = $urandom_range(0, 40);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, wc + 2) : -1;
            if (wc != 0 && ab >= 0 && ab < wc) begin
                en  = ab;
                eab = 1'b1;
            end else begin
                en  = wc;
                eab = 1'b0;
            end
            run_load($sformatf("rnd%0d", r), sa, wc, ab, 2, 1'b1, en, eab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
